// File: rtl/kuznechik_pkg.sv
// Shared constants and state encoding for the Kuznechik key-schedule blocks.
package kuznechik_pkg;
    localparam int KUZ_KW    = 128;
    localparam int KUZ_NKEYS = 10;
    localparam int KUZ_IW    = 4;

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        REPLAY
    } keyseq_state_t;
endpackage

// File: rtl/kuznechik_key_ram.sv
// NKEYS x KW round-key register file: each write fills two adjacent slots,
// one asynchronous read port.
module kuznechik_key_ram
    import kuznechik_pkg::*;
#(
    parameter int NKEYS = KUZ_NKEYS,
    parameter int KW    = KUZ_KW
)
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [KUZ_IW-1:0] i_wr_addr,
    input  logic [2*KW-1:0]   i_wr_data,
    input  logic [KUZ_IW-1:0] i_rd_addr,
    output logic [KW-1:0]     o_rd_data
);
    logic [KW-1:0]     r_mem [NKEYS];
    logic [KUZ_IW-1:0] w_wr_addr_hi;

    assign w_wr_addr_hi = i_wr_addr + KUZ_IW'(1);

    // Upper half of the pair is the even key, lower half the odd key.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr]    <= i_wr_data[2*KW-1:KW];
            r_mem[w_wr_addr_hi] <= i_wr_data[KW-1:0];
        end
    end

    assign o_rd_data = (i_rd_addr < KUZ_IW'(NKEYS)) ? r_mem[i_rd_addr] : '0;
endmodule

// File: rtl/kuznechik_key_sequencer.sv
// Round-key buffer between keygen and encryptor: fills from key pairs, replays
// over valid/ready. Define KUZ_KEYSEQ_REVERSE_EN to add the decrypt (reverse) order.
module kuznechik_key_sequencer
    import kuznechik_pkg::*;
#(
    parameter int NKEYS = KUZ_NKEYS,
    parameter int KW    = KUZ_KW
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_pair_valid,
    input  logic [2*KW-1:0]   i_pair_in,
    input  logic              i_replay_req,
`ifdef KUZ_KEYSEQ_REVERSE_EN
    input  logic              i_decrypt,
`endif
    input  logic              i_key_ready,
    output logic              o_key_valid,
    output logic [KW-1:0]     o_round_key,
    output logic [KUZ_IW-1:0] o_key_index,
    output logic              o_store_full,
    output logic              o_replay_done,
    output logic              o_overflow
);
    localparam logic [KUZ_IW-1:0] LAST_SLOT = KUZ_IW'(NKEYS - 1);
    localparam logic [KUZ_IW-1:0] LAST_PAIR = KUZ_IW'(NKEYS - 2);

    keyseq_state_t     r_state;
    logic [KUZ_IW-1:0] r_wr_ptr;
    logic [KUZ_IW-1:0] r_rd_ptr;
    logic              r_reverse;
    logic              r_key_valid;
    logic [KW-1:0]     r_round_key;
    logic [KUZ_IW-1:0] r_key_index;
    logic              r_store_full;
    logic              r_replay_done;
    logic              r_overflow;

    logic              w_dec_req;
    logic              w_we;
    logic              w_accept;
    logic [KUZ_IW-1:0] w_rd_addr;
    logic [KUZ_IW-1:0] w_end_slot;
    logic [KW-1:0]     w_rd_data;

`ifdef KUZ_KEYSEQ_REVERSE_EN
    assign w_dec_req = i_decrypt;
`else
    assign w_dec_req = 1'b0;
`endif

    assign w_we       = (r_state == FILL) && i_pair_valid && !i_load && !i_rst;
    assign w_accept   = r_key_valid && i_key_ready;
    assign w_end_slot = r_reverse ? '0 : LAST_SLOT;

    // Address of the key to register next: the first slot when starting, else the neighbour.
    always_comb begin
        w_rd_addr = r_rd_ptr;
        if (r_state == IDLE)
            w_rd_addr = w_dec_req ? LAST_SLOT : '0;
        else if (r_reverse)
            w_rd_addr = r_rd_ptr - KUZ_IW'(1);
        else
            w_rd_addr = r_rd_ptr + KUZ_IW'(1);
    end

    kuznechik_key_ram #(.NKEYS(NKEYS), .KW(KW)) u_ram (
        .i_clk     (i_clk),
        .i_we      (w_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_pair_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            r_state       <= FILL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_reverse     <= 1'b0;
            r_key_valid   <= 1'b0;
            r_round_key   <= '0;
            r_key_index   <= '0;
            r_store_full  <= 1'b0;
            r_replay_done <= 1'b0;
            if (i_rst)
                r_overflow <= 1'b0;
        end else begin
            r_replay_done <= 1'b0;
            if (i_pair_valid && r_state != FILL)
                r_overflow <= 1'b1;
            case (r_state)
                FILL: begin
                    if (i_pair_valid) begin
                        r_wr_ptr <= r_wr_ptr + KUZ_IW'(2);
                        if (r_wr_ptr == LAST_PAIR) begin
                            r_state      <= IDLE;
                            r_store_full <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (i_replay_req) begin
                        r_state     <= REPLAY;
                        r_reverse   <= w_dec_req;
                        r_rd_ptr    <= w_rd_addr;
                        r_key_valid <= 1'b1;
                        r_round_key <= w_rd_data;
                        r_key_index <= w_rd_addr;
                    end
                end
                REPLAY: begin
                    if (w_accept) begin
                        if (r_rd_ptr == w_end_slot) begin
                            r_state       <= IDLE;
                            r_key_valid   <= 1'b0;
                            r_replay_done <= 1'b1;
                        end else begin
                            r_rd_ptr    <= w_rd_addr;
                            r_round_key <= w_rd_data;
                            r_key_index <= w_rd_addr;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign o_key_valid   = r_key_valid;
    assign o_round_key   = r_round_key;
    assign o_key_index   = r_key_index;
    assign o_store_full  = r_store_full;
    assign o_replay_done = r_replay_done;
    assign o_overflow    = r_overflow;
endmodule

// File: doc/kuznechik_key_sequencer.md
# kuznechik_key_sequencer

Round-key buffer that sits between `kuznechik_keygen` and `kuznechik_encrypt`. It collects the five 256-bit round-key pairs produced by the key schedule into a 10-entry × 128-bit store. On request, it replays the keys one at a time over a valid/ready handshake. This removes the keygen→encryptor timing coupling and lets every block reuse the same schedule without regenerating keys.

## Interface
- `NKEYS`, 10: number of 128-bit round keys held (fixed at 10 for Kuznechik; even values only).
- `KW`, 128: round-key width.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous and active-high.
- `load`  in  1  pulse: discard the stored schedule and start a new fill.
- `pair_valid`  in  1  keygen `ready` pulse; `pair_in` is valid this cycle.
- `pair_in`  in  2*KW  key pair: `[2KW-1:KW]` = K(2i), `[KW-1:0]` = K(2i+1).
- `replay_req`  in  1  pulse: start streaming the stored schedule.
- `key_ready`  in  1  consumer accepts `round_key` this cycle.
- `key_valid`  out  1  `round_key` is valid.
- `round_key`  out  KW  current round key.
- `key_index`  out  4  slot index of `round_key`.
- `store_full`  out  1  all NKEYS slots written.
- `replay_done`  out  1  one-cycle pulse after the last key is accepted.
- `overflow`  out  1  sticky: a pair arrived when it could not be accepted.

## Operation
- States: FILL, IDLE, REPLAY.
- Reset (and `load`) → FILL. Effects: `wr_ptr`=0, `store_full`=0, `key_valid`=0, `round_key`=0, `key_index`=0, `replay_done`=0.
- `overflow` is cleared by reset only.
- FILL: each `pair_valid` writes K(2i) to slot `wr_ptr` and K(2i+1) to slot `wr_ptr+1`, then `wr_ptr += 2`.
- FILL exit: when the write of slots NKEYS-2/NKEYS-1 occurs, go to IDLE with `store_full`=1.
- IDLE: `replay_req` → REPLAY with `rd_ptr`=0.
- REPLAY: `round_key` = slot[`rd_ptr`], `key_index` = `rd_ptr`, `key_valid`=1.
  - On `key_valid && key_ready`: `rd_ptr++`.
  - After slot NKEYS-1 is accepted → IDLE, `replay_done`=1 for one cycle, `key_valid`=0.
- `round_key` and `key_index` hold their value while `key_valid && !key_ready`.
- Boundary rules:
  - `pair_valid` in IDLE or REPLAY: dropped, `overflow` set.
  - `replay_req` in FILL or REPLAY: ignored.
  - `load` in any state: aborts immediately. Next cycle `key_valid`=0 and the state is FILL. A `pair_valid` in the same cycle as `load` is dropped, without setting `overflow`.
  - `rst` mid-replay: same effect as `load`, and additionally clears `overflow`.
  - Store contents are not cleared on `load`; `store_full` gates all use.

## Timing
- `pair_valid` at cycle t: slots are written at the edge ending t.
- Fifth `pair_valid` at t: `store_full`=1 from t+1.
- `replay_req` at t in IDLE: `key_valid`=1 with slot 0 from t+1 (registered output, latency 1).
- `key_ready` held high: one key per cycle, so 10 keys occupy cycles t+1..t+10, `replay_done` at t+11, and `key_valid`=0 at t+11.
- Back-to-back: `replay_req` is accepted on the `replay_done` cycle; the next slot 0 appears one cycle later.
- All outputs are registered. There is no combinational path from `key_ready` to `round_key`.

## Configuration
- `KUZ_KEYSEQ_REVERSE_EN` defined:
  - Adds input port `decrypt` (1 bit), sampled on the `replay_req` cycle.
  - When set, replay order is slot NKEYS-1 down to 0 and `key_index` reports the actual slot.
  - Done condition becomes "slot 0 accepted".
- Not defined: the `decrypt` port does not exist and replay is forward order only.

## Structure
- Shared package `kuznechik_pkg`:
  - Constants `KUZ_KW`=128 and `KUZ_NKEYS`=10.
  - State encoding typedef `keyseq_state_t` {FILL, IDLE, REPLAY}.
- One sub-module: `kuznechik_key_ram`, an NKEYS×KW register file with a dual-slot write port (two adjacent slots per write) and one asynchronous read port.

## Test plan
- Fill and forward replay:
  - Stimulus: 5 pairs with K(n) = {120'h0, 8'(n)}, then `replay_req` with `key_ready`=1.
  - Response: `round_key` = 0..9 over 10 consecutive cycles, `key_index` 0..9, `replay_done` one cycle after key 9.
- Backpressure: toggle `key_ready` 1,0,0,1… → every key appears exactly once, in order; `round_key` is stable while stalled.
- Early and overflow requests:
  - `replay_req` after 3 pairs → no `key_valid`.
  - A sixth `pair_valid` in IDLE → `overflow`=1 and the store is unchanged on the next replay.
- `load` during REPLAY after key 4 → `key_valid`=0 next cycle, `store_full`=0; refill with new values → replay shows only the new values.
- Synchronous reset: assert `rst` at key 6 → every output is at its reset value the next cycle, including `overflow`=0.
- With `KUZ_KEYSEQ_REVERSE_EN`: `decrypt`=1 at `replay_req` → keys 9..0, `key_index` 9..0, `replay_done` after slot 0.
